// File: rtl/nios2_oci_dct_monitor_if.sv
// Trace monitor bus: capture inputs, end-of-test handshake and the drain read port.
interface nios2_oci_dct_monitor_if #(
   parameter int unsigned DATA_W  = 30,
   parameter int unsigned COUNT_W = 4,
   parameter int unsigned DEPTH   = 16
);
   logic                       arm;
   logic [DATA_W-1:0]          dct_buffer;
   logic [COUNT_W-1:0]         dct_count;
   logic                       test_ending;
   logic                       test_has_ended;
   logic                       rd_ready;
   logic                       rd_valid;
   logic [DATA_W-1:0]          rd_data;
   logic [COUNT_W-1:0]         rd_tag;
   logic [$clog2(DEPTH):0]     fill_level;
   logic [15:0]                overflow_count;
   logic                       seq_error;
   logic [1:0]                 state;

   // Trace source / consumer side.
   modport master (
      output arm, dct_buffer, dct_count, test_ending, test_has_ended, rd_ready,
      input  rd_valid, rd_data, rd_tag, fill_level, overflow_count, seq_error, state
   );

   // Monitor side.
   modport slave (
      input  arm, dct_buffer, dct_count, test_ending, test_has_ended, rd_ready,
      output rd_valid, rd_data, rd_tag, fill_level, overflow_count, seq_error, state
   );
endinterface

// File: rtl/nios2_oci_dct_monitor.sv
// Debug-capture-trace monitor: samples dct_buffer on each dct_count change, checks
// count contiguity, buffers entries in a small FIFO and tracks the end-of-test protocol.
module nios2_oci_dct_monitor #(
   parameter int unsigned DATA_W    = 30,
   parameter int unsigned COUNT_W   = 4,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned FULL_MODE = 0
) (
   input logic                    clk,
   input logic                    reset,
   nios2_oci_dct_monitor_if.slave bus
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LvlW = PtrW + 1;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCapture = 2'd1,
      StDrain   = 2'd2,
      StDone    = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [COUNT_W-1:0] prev_count_q, prev_count_d;
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]    level_q, level_d;
   logic [15:0]        ovf_q, ovf_d;
   logic               seq_err_q, seq_err_d;
   logic               ended_seen_q, ended_seen_d;

   logic [COUNT_W-1:0] tag_mem_q  [DEPTH];
   logic [DATA_W-1:0]  data_mem_q [DEPTH];

   logic               empty;
   logic               full;
   logic               pop;
   logic               capture;
   logic               write_en;
   logic               grow;
   logic [COUNT_W-1:0] count_expect;

   // Capture detection, sequence check and FIFO pointer/level bookkeeping.
   always_comb begin
      empty        = (level_q == '0);
      full         = (level_q == LvlW'(DEPTH));
      pop          = !empty && bus.rd_ready;
      capture      = (state_q == StCapture) && (bus.dct_count != prev_count_q);
      count_expect = prev_count_q + COUNT_W'(1);

      prev_count_d = prev_count_q;
      seq_err_d    = seq_err_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      ovf_d        = ovf_q;
      write_en     = 1'b0;
      grow         = 1'b0;

      if (state_q == StIdle) begin
         prev_count_d = bus.dct_count;
      end

      if (capture) begin
         prev_count_d = bus.dct_count;
         if (bus.dct_count != count_expect) begin
            seq_err_d = 1'b1;
         end
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      if (capture) begin
         if (!full || pop) begin
            write_en = 1'b1;
            grow     = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end else begin
            // Full with no pop: either drop the newcomer or evict the oldest entry.
            if (FULL_MODE != 0) begin
               write_en = 1'b1;
               wr_ptr_d = wr_ptr_q + PtrW'(1);
               rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (ovf_q != 16'hFFFF) begin
               ovf_d = ovf_q + 16'd1;
            end
         end
      end

      level_d = level_q;
      if (grow && !pop) begin
         level_d = level_q + LvlW'(1);
      end else if (!grow && pop) begin
         level_d = level_q - LvlW'(1);
      end
   end

   // Capture / drain / done sequencing; level_d lets DONE be reached on the last pop.
   always_comb begin
      state_d      = state_q;
      ended_seen_d = ended_seen_q;
      case (state_q)
         StIdle: begin
            if (bus.arm) begin
               state_d = StCapture;
            end
         end
         StCapture: begin
            if (bus.test_has_ended) begin
               ended_seen_d = 1'b1;
               state_d      = (level_d == '0) ? StDone : StDrain;
            end else if (bus.test_ending) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (bus.test_has_ended) begin
               ended_seen_d = 1'b1;
            end
            if ((ended_seen_q || bus.test_has_ended) && (level_d == '0)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Control and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         prev_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         ovf_q        <= '0;
         seq_err_q    <= 1'b0;
         ended_seen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_count_q <= prev_count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         ovf_q        <= ovf_d;
         seq_err_q    <= seq_err_d;
         ended_seen_q <= ended_seen_d;
      end
   end

   // Entry storage; contents need no reset because rd_valid gates the read port.
   always_ff @(posedge clk) begin
      if (write_en && !reset) begin
         tag_mem_q[wr_ptr_q]  <= bus.dct_count;
         data_mem_q[wr_ptr_q] <= bus.dct_buffer;
      end
   end

   // Read port and status outputs.
   always_comb begin
      bus.rd_valid       = !empty;
      bus.rd_data        = empty ? '0 : data_mem_q[rd_ptr_q];
      bus.rd_tag         = empty ? '0 : tag_mem_q[rd_ptr_q];
      bus.fill_level     = level_q;
      bus.overflow_count = ovf_q;
      bus.seq_error      = seq_err_q;
      bus.state          = state_q;
   end

endmodule

// File: tb/tb_nios2_oci_dct_monitor.sv
// Bench for nios2_oci_dct_monitor: drop-newest and overwrite-oldest instances share
// stimulus; a queue-based reference model predicts every output each cycle.
module tb_nios2_oci_dct_monitor;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        t_rst;
   logic        t_arm;
   logic [29:0] t_buf;
   logic [3:0]  t_cnt;
   logic        t_ending;
   logic        t_ended;
   logic        t_rdy;

   int vectors     = 0;
   int miscompares = 0;

   nios2_oci_dct_monitor_if #(.DATA_W(30), .COUNT_W(4), .DEPTH(4)) if0 ();
   nios2_oci_dct_monitor_if #(.DATA_W(30), .COUNT_W(4), .DEPTH(4)) if1 ();

   assign if0.arm            = t_arm;
   assign if0.dct_buffer     = t_buf;
   assign if0.dct_count      = t_cnt;
   assign if0.test_ending    = t_ending;
   assign if0.test_has_ended = t_ended;
   assign if0.rd_ready       = t_rdy;
   assign if1.arm            = t_arm;
   assign if1.dct_buffer     = t_buf;
   assign if1.dct_count      = t_cnt;
   assign if1.test_ending    = t_ending;
   assign if1.test_has_ended = t_ended;
   assign if1.rd_ready       = t_rdy;

   nios2_oci_dct_monitor #(.DATA_W(30), .COUNT_W(4), .DEPTH(4), .FULL_MODE(0)) u_dut0 (
      .clk   (clk),
      .reset (t_rst),
      .bus   (if0)
   );

   nios2_oci_dct_monitor #(.DATA_W(30), .COUNT_W(4), .DEPTH(4), .FULL_MODE(1)) u_dut1 (
      .clk   (clk),
      .reset (t_rst),
      .bus   (if1)
   );

   // Reference model, one slot per full policy. Entries are {tag, data}.
   logic [33:0] mq [2][$];
   int          m_prev  [2];
   int          m_st    [2];
   int          m_ovf   [2];
   bit          m_seq   [2];
   bit          m_ended [2];

   task automatic model_step(input int m);
      bit          pop;
      bit          cap;
      int          pre;
      logic [33:0] e;
      if (t_rst) begin
         mq[m].delete();
         m_prev[m] = 0; m_st[m] = 0; m_ovf[m] = 0; m_seq[m] = 0; m_ended[m] = 0;
         return;
      end
      pre = mq[m].size();
      pop = (pre != 0) && t_rdy;
      cap = (m_st[m] == 1) && (int'(t_cnt) != m_prev[m]);
      e   = {t_cnt, t_buf};
      if (m_st[m] == 0) m_prev[m] = int'(t_cnt);
      if (cap) begin
         if (((m_prev[m] + 1) % 16) != int'(t_cnt)) m_seq[m] = 1;
         m_prev[m] = int'(t_cnt);
      end
      if (pop) void'(mq[m].pop_front());
      if (cap) begin
         if (pre < 4 || pop) begin
            mq[m].push_back(e);
         end else begin
            if (m_ovf[m] < 65535) m_ovf[m]++;
            if (m == 1) begin
               void'(mq[m].pop_front());
               mq[m].push_back(e);
            end
         end
      end
      case (m_st[m])
         0: if (t_arm) m_st[m] = 1;
         1: begin
            if (t_ended) begin
               m_ended[m] = 1;
               m_st[m] = (mq[m].size() == 0) ? 3 : 2;
            end else if (t_ending) begin
               m_st[m] = 2;
            end
         end
         2: begin
            if (t_ended) m_ended[m] = 1;
            if (m_ended[m] && mq[m].size() == 0) m_st[m] = 3;
         end
         default: ;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_mode(input int m, input logic v, input logic [29:0] d,
                           input logic [3:0] t, input logic [2:0] lvl,
                           input logic [15:0] ov, input logic se, input logic [1:0] st);
      logic [33:0] head;
      bit          has;
      has  = (mq[m].size() != 0);
      head = has ? mq[m][0] : 34'd0;
      chk($sformatf("m%0d rd_valid", m), 32'(v), 32'(has));
      chk($sformatf("m%0d rd_data", m), 32'(d), 32'(head[29:0]));
      chk($sformatf("m%0d rd_tag", m), 32'(t), 32'(head[33:30]));
      chk($sformatf("m%0d fill_level", m), 32'(lvl), 32'(mq[m].size()));
      chk($sformatf("m%0d overflow_count", m), 32'(ov), 32'(m_ovf[m]));
      chk($sformatf("m%0d seq_error", m), 32'(se), 32'(m_seq[m]));
      chk($sformatf("m%0d state", m), 32'(st), 32'(m_st[m]));
   endtask

   task automatic tick();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      chk_mode(0, if0.rd_valid, if0.rd_data, if0.rd_tag, if0.fill_level,
               if0.overflow_count, if0.seq_error, if0.state);
      chk_mode(1, if1.rd_valid, if1.rd_data, if1.rd_tag, if1.fill_level,
               if1.overflow_count, if1.seq_error, if1.state);
   endtask

   task automatic do_reset();
      t_rst = 1'b1; t_arm = 1'b0; t_ending = 1'b0; t_ended = 1'b0;
      tick();
      t_rst = 1'b0;
   endtask

   initial begin
      t_rst = 1'b1; t_arm = 1'b0; t_buf = '0; t_cnt = '0;
      t_ending = 1'b0; t_ended = 1'b0; t_rdy = 1'b0;
      @(posedge clk); #1;
      tick();
      tick();
      chk("reset state", 32'(if0.state), 32'd0);
      chk("reset rd_valid", 32'(if1.rd_valid), 32'd0);
      t_rst = 1'b0;
      tick();

      // Basic capture with a ready consumer.
      t_rdy = 1'b1; t_arm = 1'b1; tick(); t_arm = 1'b0;
      t_cnt = 4'd1; t_buf = 30'h1111111; tick();
      chk("basic tag1", 32'(if0.rd_tag), 32'd1);
      t_cnt = 4'd2; t_buf = 30'h2222222; tick();
      chk("basic data2", 32'(if0.rd_data), 32'h2222222);
      tick();
      chk("basic drained", 32'(if0.fill_level), 32'd0);

      // Gap 2->5 flags, then a 15->0 wrap keeps it set.
      t_cnt = 4'd5; tick();
      chk("gap seq_error", 32'(if0.seq_error), 32'd1);
      t_cnt = 4'd15; tick(); t_cnt = 4'd0; tick(); tick();

      // Wrap-only run must stay clean.
      do_reset();
      t_cnt = 4'd14; tick();
      t_arm = 1'b1; tick(); t_arm = 1'b0;
      t_cnt = 4'd15; t_buf = 30'h0ABCDEF; tick();
      t_cnt = 4'd0;  t_buf = 30'h1234567; tick(); tick();
      chk("wrap seq_error", 32'(if1.seq_error), 32'd0);

      // Overflow with a stalled consumer, counts 1..6.
      do_reset();
      t_cnt = 4'd0; t_rdy = 1'b0; t_arm = 1'b1; tick(); t_arm = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         t_cnt = 4'(i); t_buf = 30'($urandom); tick();
      end
      chk("ovf fill m0", 32'(if0.fill_level), 32'd4);
      chk("ovf count m1", 32'(if1.overflow_count), 32'd2);
      chk("ovf head m0", 32'(if0.rd_tag), 32'd1);
      chk("ovf head m1", 32'(if1.rd_tag), 32'd3);

      // Full with simultaneous push and pop.
      t_rdy = 1'b1; t_cnt = 4'd7; t_buf = 30'($urandom); tick();
      chk("full push+pop fill", 32'(if0.fill_level), 32'd4);
      chk("full push+pop ovf", 32'(if0.overflow_count), 32'd2);
      repeat (5) tick();

      // End protocol: three held, drain, then done after the third pop.
      do_reset();
      t_cnt = 4'd0; t_rdy = 1'b0; t_arm = 1'b1; tick(); t_arm = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         t_cnt = 4'(i); t_buf = 30'($urandom); tick();
      end
      t_ending = 1'b1; tick(); t_ending = 1'b0;
      chk("end drain state", 32'(if0.state), 32'd2);
      t_cnt = 4'd4; tick();
      chk("end ignores count", 32'(if0.fill_level), 32'd3);
      t_ended = 1'b1; t_rdy = 1'b1;
      tick(); tick(); tick();
      chk("end done state", 32'(if1.state), 32'd3);
      t_ended = 1'b0; tick();

      // Reset while draining, then re-arm.
      do_reset();
      t_cnt = 4'd0; t_rdy = 1'b0; t_arm = 1'b1; tick(); t_arm = 1'b0;
      t_cnt = 4'd1; t_buf = 30'($urandom); tick();
      t_cnt = 4'd2; t_buf = 30'($urandom); tick();
      t_ending = 1'b1; tick(); t_ending = 1'b0;
      t_rst = 1'b1; tick(); t_rst = 1'b0;
      chk("rst mid-drain fill", 32'(if0.fill_level), 32'd0);
      chk("rst mid-drain state", 32'(if0.state), 32'd0);
      t_cnt = 4'd0; tick();
      t_arm = 1'b1; tick(); t_arm = 1'b0;
      t_cnt = 4'd1; t_buf = 30'($urandom); tick();
      chk("rearm capture", 32'(if0.fill_level), 32'd1);

      // Randomized runs: mostly contiguous counts, random stalls and end signalling.
      for (int r = 0; r < 6; r++) begin
         do_reset();
         t_cnt = 4'($urandom_range(0, 15)); tick();
         t_arm = 1'b1; tick(); t_arm = 1'b0;
         for (int i = 0; i < 50; i++) begin
            int p;
            p = $urandom_range(0, 9);
            if (p < 6) t_cnt = t_cnt + 4'd1;
            else if (p == 6) t_cnt = 4'($urandom_range(0, 15));
            t_buf    = 30'($urandom);
            t_rdy    = ($urandom_range(0, 2) != 0);
            t_ending = (i > 30) && ($urandom_range(0, 15) == 0);
            t_ended  = (i > 35) && ($urandom_range(0, 7) == 0);
            tick();
         end
         t_ending = 1'b0; t_ended = 1'b1; t_rdy = 1'b1;
         repeat (8) tick();
         t_ended = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/nios2_oci_dct_monitor.md
# nios2_oci_dct_monitor

Parametrised debug-capture-trace monitor for the Nios II OCI simulation/debug path. It samples the OCI `dct_buffer` word whenever `dct_count` advances, and checks that the count sequence is contiguous. It buffers captured words in a DEPTH-entry FIFO with selectable full policy and drains them over a valid/ready read port. It also tracks the test-ending / test-ended protocol so a bench or debug host knows when the trace is complete.

## Interface

Parameters:
- DATA_W, 30, width of `dct_buffer` / `rd_data`
- COUNT_W, 4, width of `dct_count` / `rd_tag`
- DEPTH, 16, FIFO entries; power of two, ≥2
- FULL_MODE, 0, 0 = drop newest when full, 1 = overwrite oldest

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- arm  in  1  starts capture from IDLE
- dct_buffer  in  DATA_W  trace word
- dct_count  in  COUNT_W  trace sequence count
- test_ending  in  1  stop capturing, begin drain
- test_has_ended  in  1  test complete
- rd_ready  in  1  consumer accepts head entry
- rd_valid  out  1  FIFO non-empty
- rd_data  out  DATA_W  head entry word
- rd_tag  out  COUNT_W  `dct_count` captured with head entry
- fill_level  out  $clog2(DEPTH)+1  entries held
- overflow_count  out  16  entries lost, saturates at 16'hFFFF
- seq_error  out  1  sticky, non-contiguous count seen
- state  out  2  0 IDLE, 1 CAPTURE, 2 DRAIN, 3 DONE

## Operation

- `prev_count` register:
  - Loads `dct_count` every cycle in IDLE.
  - Loads the new count on every capture event.
- Capture event: state == CAPTURE and `dct_count != prev_count`. The event pushes {`dct_count`, `dct_buffer`}.
- Sequence check: on each capture event, `dct_count != prev_count+1` (mod 2^COUNT_W) sets `seq_error`. 15→0 with COUNT_W=4 is legal. `seq_error` clears only on reset.
- Pop: `rd_valid && rd_ready`. `rd_data`/`rd_tag` show the head entry combinationally from storage.
- Full handling, when a push occurs with the FIFO full and no pop:
  - FULL_MODE=0: the new entry is discarded; `overflow_count`+1.
  - FULL_MODE=1: the new entry is written, the oldest is discarded (read pointer advances), and `overflow_count`+1.
- Push and pop in the same cycle while full: both happen, no overflow, `fill_level` unchanged.
- Push and pop in the same cycle while empty: impossible, since `rd_valid`=0.
- Pointers wrap modulo DEPTH.
- FSM:
  - IDLE → CAPTURE when `arm`=1.
  - CAPTURE → DRAIN when `test_ending`=1. A capture event in that same cycle is still accepted.
  - CAPTURE or DRAIN → DONE when `test_has_ended`=1 and the FIFO will be empty after this cycle's pop.
  - CAPTURE → DRAIN when `test_has_ended`=1 and the FIFO is not empty.
  - DRAIN → DONE when the FIFO becomes empty and `test_has_ended` has been seen. A sticky `ended_seen` flag records it.
  - DONE holds until reset; no captures are taken and pops are still permitted.
  - `arm` is ignored outside IDLE.
- No captures are taken in IDLE, DRAIN or DONE.

## Timing

- Reset (synchronous, one cycle):
  - All outputs go to 0: `rd_valid`=0, `rd_data`=0, `rd_tag`=0, `fill_level`=0, `overflow_count`=0, `seq_error`=0, `state`=IDLE.
  - FIFO pointers and `ended_seen` clear.
  - Reset mid-operation discards all entries and takes effect on the next edge regardless of other inputs.
- Capture latency: a count change sampled at edge N is written at edge N. `rd_valid`/`fill_level` reflect it after edge N (visible in cycle N+1).
- Pop latency: `rd_data`/`rd_tag` update to the next entry in the cycle after the pop edge.
- `seq_error` and `overflow_count` update at the same edge as the triggering push.
- `state` is a registered output; each transition is visible one cycle after its condition is sampled.
- Throughput: one capture per cycle and one pop per cycle, sustained.

## Test plan

All scenarios use DEPTH=4, DATA_W=30, COUNT_W=4 unless stated.

- **Basic capture:** arm; count 0→1→2 with buffer 30'h1111111 then 30'h2222222; rd_ready=1. Expect `rd_valid` one cycle after each change, tags 1 then 2 with matching data, `seq_error`=0, `fill_level` returning to 0.
- **Sequence gap and wrap:** counts 2→5, then 15→0. Expect `seq_error`=1 on the cycle after the 5 capture and it stays high. A separate run with only 15→0 keeps `seq_error`=0.
- **Overflow:** rd_ready=0, counts 1..6.
  - FULL_MODE=0: `fill_level`=4, `overflow_count`=2, and draining yields tags 1,2,3,4.
  - FULL_MODE=1: same `fill_level` and `overflow_count`, and draining yields tags 3,4,5,6.
- **Full plus simultaneous pop:** FIFO full, push and pop in the same cycle. Expect `fill_level` stays 4 and `overflow_count` is unchanged.
- **End protocol:** 3 entries held; pulse test_ending. Expect state=DRAIN and further count changes ignored. Assert test_has_ended, then pop 3 entries. Expect state=DONE the cycle after the third pop.
- **Reset mid-drain:** reset asserted in DRAIN with 2 entries. Expect all outputs 0 and state=IDLE the next cycle; re-arm works normally.
